// File: rtl/result_tx_if.sv
// rtl/result_tx_if.sv - result RAM read port and UART byte port of the result dumper
interface result_tx_if #(
  parameter int UNITS_X  = 2,
  parameter int Bitwidth = 8,
  parameter int ADDR_W   = 4
);
  logic [ADDR_W-1:0]           RD_ADDR;
  logic [UNITS_X*Bitwidth-1:0] RD_DATA;
  logic [7:0]                  TX_DATA;
  logic                        TX_WR;
  logic                        TX_BUSY;

  modport master (
    output RD_ADDR,
    input  RD_DATA,
    output TX_DATA,
    output TX_WR,
    input  TX_BUSY
  );

  modport slave (
    input  RD_ADDR,
    output RD_DATA,
    input  TX_DATA,
    input  TX_WR,
    output TX_BUSY
  );
endinterface

// File: rtl/result_tx.sv
// rtl/result_tx.sv - dumps the result RAM as decimal CSV text over a byte-wide UART port
module result_tx #(
  parameter int UNITS_X  = 2,
  parameter int UNITS_Y  = 2,
  parameter int Bitwidth = 8,
  parameter int ADDR_W   = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  result_tx_if.master bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] LATCH  = 3'd2;
  localparam logic [2:0] SEND   = 3'd3;
  localparam logic [2:0] GUARD  = 3'd4;
  localparam logic [2:0] WAIT   = 3'd5;
  localparam logic [2:0] NEXT   = 3'd6;
  localparam logic [2:0] FINISH = 3'd7;

  localparam int CW = (UNITS_X > 1) ? $clog2(UNITS_X) : 1;

  logic [2:0]                  state;
  logic                        start_q;
  logic                        start_armed;
  logic [ADDR_W-1:0]           row;
  logic [CW-1:0]               col;
  logic [2:0]                  chr;
  logic [UNITS_X*Bitwidth-1:0] row_reg;
  logic [7:0]                  tx_data_q;
  logic [7:0]                  col_val;
  logic [7:0]                  cur_char;
  logic                        last_col;
  logic                        last_row;
  logic                        col_end;
  logic                        start_edge;

  // Column 0 lives in the most significant slice of the row word.
  always_comb begin
    col_val = '0;
    for (int c = 0; c < UNITS_X; c++) begin
      if (col == CW'(c)) col_val = 8'(row_reg[Bitwidth*(UNITS_X-1-c) +: Bitwidth]);
    end
  end

  // Characters 0..2 are the three digits, 3 is ',' or CR, 4 is LF (last column only).
  always_comb begin
    case (chr)
      3'd0:    cur_char = 8'h30 + col_val / 8'd100;
      3'd1:    cur_char = 8'h30 + (col_val / 8'd10) % 8'd10;
      3'd2:    cur_char = 8'h30 + col_val % 8'd10;
      3'd3:    cur_char = last_col ? 8'h0D : 8'h2C;
      default: cur_char = 8'h0A;
    endcase
  end

  assign last_col   = (col == CW'(UNITS_X - 1));
  assign last_row   = (row == ADDR_W'(UNITS_Y - 1));
  assign col_end    = last_col ? (chr == 3'd4) : (chr == 3'd3);
  // start_armed blocks a START that was already high when reset released.
  assign start_edge = START & ~start_q & start_armed;

  assign BUSY        = (state != IDLE);
  assign DONE        = (state == FINISH);
  assign bus.RD_ADDR = row;
  assign bus.TX_WR   = (state == SEND);
  assign bus.TX_DATA = (state == SEND) ? cur_char : tx_data_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      start_armed <= 1'b0;
      row         <= '0;
      col         <= '0;
      chr         <= '0;
      row_reg     <= '0;
      tx_data_q   <= 8'h00;
    end else begin
      start_q     <= START;
      start_armed <= start_armed | ~START;
      case (state)
        IDLE: begin
          row <= '0;
          col <= '0;
          chr <= '0;
          if (start_edge) state <= READ;
        end
        READ:  state <= LATCH;
        LATCH: begin
          row_reg <= bus.RD_DATA;
          state   <= SEND;
        end
        SEND: begin
          tx_data_q <= cur_char;
          state     <= GUARD;
        end
        GUARD: state <= WAIT;
        WAIT:  if (!bus.TX_BUSY) state <= NEXT;
        NEXT: begin
          if (!col_end) begin
            chr   <= chr + 3'd1;
            state <= SEND;
          end else begin
            chr <= '0;
            if (!last_col) begin
              col   <= col + 1'b1;
              state <= SEND;
            end else begin
              col <= '0;
              if (last_row) begin
                state <= FINISH;
              end else begin
                row   <= row + 1'b1;
                state <= READ;
              end
            end
          end
        end
        FINISH: begin
          row   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_tx.sv
// tb/tb_result_tx.sv - randomized and directed self-checking bench for result_tx
module tb_result_tx;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic start_a = 1'b0, busy_a, done_a;
  logic start_b = 1'b0, busy_b, done_b;

  always #5 CLK = ~CLK;

  result_tx_if #(.UNITS_X(2), .Bitwidth(8), .ADDR_W(4)) ifa ();
  result_tx_if #(.UNITS_X(3), .Bitwidth(8), .ADDR_W(4)) ifb ();

  result_tx #(.UNITS_X(2), .UNITS_Y(2), .Bitwidth(8), .ADDR_W(4)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .START(start_a), .BUSY(busy_a), .DONE(done_a), .bus(ifa)
  );
  result_tx #(.UNITS_X(3), .UNITS_Y(1), .Bitwidth(8), .ADDR_W(4)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .START(start_b), .BUSY(busy_b), .DONE(done_b), .bus(ifb)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] ram_a [16][2];
  logic [7:0] ram_b [16][3];
  int busy_len_a = 10, busy_len_b = 3;
  int bcnt_a = 0, bcnt_b = 0;

  // RAM with one-cycle read latency; column 0 in the MSBs
  always @(posedge CLK) begin
    ifa.RD_DATA <= {ram_a[ifa.RD_ADDR][0], ram_a[ifa.RD_ADDR][1]};
    ifb.RD_DATA <= {ram_b[ifb.RD_ADDR][0], ram_b[ifb.RD_ADDR][1], ram_b[ifb.RD_ADDR][2]};
    cyc <= cyc + 1;
  end

  // UART model: busy for busy_len cycles starting the cycle after TX_WR
  always @(posedge CLK) begin
    if (ifa.TX_WR) bcnt_a <= busy_len_a;
    else if (bcnt_a != 0) bcnt_a <= bcnt_a - 1;
    if (ifb.TX_WR) bcnt_b <= busy_len_b;
    else if (bcnt_b != 0) bcnt_b <= bcnt_b - 1;
  end
  assign ifa.TX_BUSY = (bcnt_a != 0);
  assign ifb.TX_BUSY = (bcnt_b != 0);

  logic [7:0] got_a[$], got_b[$], exp[$];
  logic [3:0] addr_log_a[$];
  int ndone_a = 0, ndone_b = 0, bytes_at_done_a = -1, bytes_at_done_b = -1;
  int last_wr_a = -100, last_wr_b = -100;

  always @(negedge CLK) begin
    if (ifa.TX_WR) begin
      checks++;
      assert (ifa.TX_BUSY === 1'b0) else begin
        errors++; $error("FAIL wr_while_busy_a: TX_BUSY=%0b required 0", ifa.TX_BUSY);
      end
      checks++;
      assert (cyc - last_wr_a >= 3) else begin
        errors++; $error("FAIL wr_gap_a: gap %0d cycles, required >= 3", cyc - last_wr_a);
      end
      last_wr_a = cyc;
      got_a.push_back(ifa.TX_DATA);
    end
    if (done_a) begin ndone_a++; bytes_at_done_a = got_a.size(); end
    if (busy_a && (addr_log_a.size() == 0 || addr_log_a[$] != ifa.RD_ADDR))
      addr_log_a.push_back(ifa.RD_ADDR);
    if (ifb.TX_WR) begin
      checks++;
      assert (ifb.TX_BUSY === 1'b0 && cyc - last_wr_b >= 3) else begin
        errors++; $error("FAIL wr_rules_b: busy=%0b gap=%0d, required busy 0 gap >= 3", ifb.TX_BUSY, cyc - last_wr_b);
      end
      last_wr_b = cyc;
      got_b.push_back(ifb.TX_DATA);
    end
    if (done_b) begin ndone_b++; bytes_at_done_b = got_b.size(); end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++; $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference text: each value as three decimal digits, ',' between columns, CR LF per row
  task automatic add_val(input logic [7:0] v, input bit last);
    string s;
    s = $sformatf("%03d", v);
    for (int i = 0; i < 3; i++) exp.push_back(s[i]);
    if (last) begin exp.push_back(8'h0D); exp.push_back(8'h0A); end
    else exp.push_back(8'h2C);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] got[$]);
    logic [7:0] g;
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      checks++;
      assert (g === exp[i]) else begin
        errors++; $error("FAIL %s_byte%0d: observed %02h expected %02h", tag, i, g, exp[i]);
      end
    end
  endtask

  // mode 0: short pulse, 1: START held 1000 cycles, 2: second edge mid-dump, 3: RAM rewritten after LATCH
  task automatic run_a(input string tag, input int mode);
    bit c0 = 0, c1 = 0;
    exp.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) add_val(ram_a[r][c], c == 1);
    got_a.delete(); addr_log_a.delete(); ndone_a = 0; bytes_at_done_a = -1;
    for (int k = 0; k < 1200; k++) begin
      start_a = (k < 2) || (mode == 1 && k < 1000) || (mode == 2 && k >= 60 && k < 63);
      if (mode == 3 && !c0 && got_a.size() >= 1) begin
        ram_a[0][0] = 8'($urandom_range(255)); ram_a[0][1] = 8'($urandom_range(255)); c0 = 1;
      end
      if (mode == 3 && !c1 && got_a.size() >= 10) begin
        ram_a[1][0] = 8'($urandom_range(255)); ram_a[1][1] = 8'($urandom_range(255)); c1 = 1;
      end
      @(negedge CLK);
    end
    start_a = 1'b0;
    check_bytes(tag, got_a);
    check({tag, "_done_pulses"}, ndone_a, 1);
    check({tag, "_done_after_last"}, bytes_at_done_a, exp.size());
    check({tag, "_addr_seq_len"}, addr_log_a.size(), 2);
    if (addr_log_a.size() >= 2) begin
      check({tag, "_addr0"}, addr_log_a[0], 0);
      check({tag, "_addr1"}, addr_log_a[1], 1);
    end
    check({tag, "_busy_idle"}, busy_a, 1'b0);
  endtask

  task automatic run_b(input string tag);
    exp.delete();
    for (int c = 0; c < 3; c++) add_val(ram_b[0][c], c == 2);
    got_b.delete(); ndone_b = 0; bytes_at_done_b = -1;
    for (int k = 0; k < 400; k++) begin
      start_b = (k < 2);
      @(negedge CLK);
    end
    check_bytes(tag, got_b);
    check({tag, "_done_pulses"}, ndone_b, 1);
    check({tag, "_done_after_last"}, bytes_at_done_b, exp.size());
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      ram_a[r][0] = 8'd0; ram_a[r][1] = 8'd0;
      for (int c = 0; c < 3; c++) ram_b[r][c] = 8'd0;
    end
    repeat (3) @(negedge CLK);
    check("rst_rd_addr", ifa.RD_ADDR, 0);
    check("rst_tx_data", ifa.TX_DATA, 8'h00);
    check("rst_tx_wr", ifa.TX_WR, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_busy_b", busy_b, 1'b0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);

    ram_a[0][0] = 8'd7; ram_a[0][1] = 8'd255; ram_a[1][0] = 8'd0; ram_a[1][1] = 8'd42;
    busy_len_a = 10;
    run_a("vec", 3);

    busy_len_a = 0;
    ram_a[0][0] = 8'd0; ram_a[0][1] = 8'd255;
    ram_a[1][0] = 8'($urandom_range(255)); ram_a[1][1] = 8'($urandom_range(255));
    run_a("nobusy", 0);

    busy_len_a = 10;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) ram_a[r][c] = 8'($urandom_range(255));
    run_a("hold", 1);
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) ram_a[r][c] = 8'($urandom_range(255));
    run_a("second_edge", 2);

    // reset in the middle of a dump
    busy_len_a = 4;
    ram_a[0][0] = 8'd7; ram_a[0][1] = 8'd255; ram_a[1][0] = 8'd0; ram_a[1][1] = 8'd42;
    got_a.delete();
    start_a = 1'b1; repeat (2) @(negedge CLK); start_a = 1'b0;
    for (int k = 0; k < 3000 && got_a.size() < 5; k++) @(negedge CLK);
    check("mid_rst_reached_5", got_a.size() >= 5, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_tx_wr", ifa.TX_WR, 1'b0);
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_tx_data", ifa.TX_DATA, 8'h00);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (60) @(negedge CLK);
    check("mid_rst_no_more_bytes", got_a.size(), 5);
    run_a("restart", 0);

    // START held through reset release must not start a dump
    RST_N = 1'b0; start_a = 1'b1;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    got_a.delete();
    repeat (60) @(negedge CLK);
    check("held_start_busy", busy_a, 1'b0);
    check("held_start_bytes", got_a.size(), 0);
    start_a = 1'b0;
    repeat (3) @(negedge CLK);
    run_a("after_held", 0);

    ram_b[0][0] = 8'd1; ram_b[0][1] = 8'd2; ram_b[0][2] = 8'd3;
    run_b("x3");
    for (int c = 0; c < 3; c++) ram_b[0][c] = 8'($urandom_range(255));
    run_b("x3_rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_tx.md
RESULT_TX -- requirements
Module: result_tx

Interface
REQ-001 Parameter UNITS_X, default 2, number of result columns (values per result row).
REQ-002 Parameter UNITS_Y, default 2, number of result rows.
REQ-003 Parameter Bitwidth, default 8, width of one result value.
REQ-004 Parameter ADDR_W, default 4, width of the result RAM read address.
REQ-005 CLK  input  1  single clock; all state changes on the rising edge.
REQ-006 RST_N  input  1  asynchronous, active-low reset.
REQ-007 START  input  1  level request (button-like); a rising edge starts one dump.
REQ-008 RD_ADDR  output  ADDR_W  read address to result RAM port B (shared by all columns).
REQ-009 RD_DATA  input  UNITS_X*Bitwidth  RAM read data; column c in bits [Bitwidth*(UNITS_X-1-c) +: Bitwidth]; 1-cycle read latency.
REQ-010 TX_DATA  output  8  byte to the UART transmitter.
REQ-011 TX_WR  output  1  one-cycle write strobe to the UART transmitter.
REQ-012 TX_BUSY  input  1  transmitter busy; high starting no later than 1 cycle after TX_WR, until the byte is sent.
REQ-013 BUSY  output  1  high while a dump is in progress.
REQ-014 DONE  output  1  one-cycle pulse when the final byte of a dump has been accepted.

Function
REQ-015 START is registered each cycle; a dump begins only on START=1 with previous sample 0, and only in IDLE.
REQ-016 States: IDLE, READ, LATCH, SEND, GUARD, WAIT, NEXT, FINISH.
REQ-017 IDLE: row=0, col=0, char=0, BUSY=0; START edge -> READ.
REQ-018 READ: drive RD_ADDR=row for one cycle -> LATCH.
REQ-019 LATCH: capture RD_DATA into a row register -> SEND; RD_ADDR holds row.
REQ-020 Per column value v (unsigned, Bitwidth<=8): characters are hundreds, tens, ones digit as ASCII ('0'+d), leading zeros kept (0 -> "000", 255 -> "255").
REQ-021 After each column except the last: ',' (0x2C); after the last column of a row: CR (0x0D) then LF (0x0A).
REQ-022 Bytes per dump = UNITS_Y*(4*UNITS_X+1); default 18.
REQ-023 SEND: TX_DATA=current character, TX_WR=1 for exactly one cycle, only entered when TX_BUSY=0 -> GUARD.
REQ-024 GUARD: one cycle, TX_WR=0, TX_BUSY ignored -> WAIT.
REQ-025 WAIT: hold while TX_BUSY=1; on TX_BUSY=0 -> NEXT.
REQ-026 NEXT: advance char; at end of column advance col; at end of row advance row and go to READ; else -> SEND; after the last LF of row UNITS_Y-1 -> FINISH.
REQ-027 FINISH: DONE=1 for one cycle -> IDLE.
REQ-028 TX_DATA holds its value from SEND until the next SEND.
REQ-029 START edges while BUSY=1 are ignored and not queued.
REQ-030 BUSY=1 in every state except IDLE.
REQ-031 Never more than one TX_WR per GUARD/WAIT sequence; TX_WR never asserted while TX_BUSY=1.
REQ-032 Row data is sampled once per row in LATCH; RAM changes afterwards do not affect that row's bytes.

Reset
REQ-033 RST_N=0 asynchronously forces IDLE, counters 0, RD_ADDR=0, TX_DATA=0x00, TX_WR=0, BUSY=0, DONE=0, START sample=0.
REQ-034 Reset during a dump abandons it with no further TX_WR; a new START edge after release restarts at row 0.
REQ-035 START held high through reset release starts no dump until it goes low and then high again.

Verification
REQ-036 Rows {7,255},{0,42}, TX_BUSY model 10 cycles after TX_WR, pulse START -> bytes "007,255\r\n000,042\r\n" (18 bytes), one DONE pulse.
REQ-037 TX_BUSY tied 0 -> 18 TX_WR pulses, each followed by at least 2 cycles of TX_WR=0; DONE after the 18th.
REQ-038 START held high for 1000 cycles -> exactly one dump; second edge mid-dump -> ignored, still 18 bytes.
REQ-039 RST_N low after the 5th byte -> TX_WR=0 and BUSY=0 immediately; no further bytes; new START -> full dump from "007".
REQ-040 RD_ADDR sequence per dump = 0 then 1; row register unchanged when RAM contents change after LATCH.
REQ-041 UNITS_X=3, UNITS_Y=1, row {1,2,3} -> "001,002,003\r\n" (13 bytes).
